// File: rtl/piso_tx.sv
// Parallel-in/serial-out frame transmitter: start bit, WIDTH data bits LSB first, stop bit.
// Define PISO_TX_PARITY_EN to insert an even-parity bit between the data and the stop bit.
`timescale 1ns/1ps
module piso_tx #(
  parameter int WIDTH      = 4,
  parameter int BIT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             load,
  output logic             ready,
  output logic             busy,
  output logic             sout,
  output logic             done
);

  localparam int CW = $clog2(BIT_CYCLES) + 1;
  localparam int IW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef PISO_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [IW-1:0]    r_idx, w_idx_nxt;
  logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
  logic             r_sout, r_ready, r_busy, r_done;
  logic             w_sout_nxt, w_ready_nxt, w_done_nxt;
  logic             w_bit_end;
`ifdef PISO_TX_PARITY_EN
  logic             r_parity, w_parity_nxt;
`endif

  assign w_bit_end = (r_cnt == LAST_CNT);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; the async reset also clears the shift register, so an
  // abandoned frame leaves nothing behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shreg  <= '0;
      r_sout   <= 1'b1;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_shreg  <= w_shreg_nxt;
      r_sout   <= w_sout_nxt;
      r_ready  <= w_ready_nxt;
      r_busy   <= ~w_ready_nxt;
      r_done   <= w_done_nxt;
`ifdef PISO_TX_PARITY_EN
      r_parity <= w_parity_nxt;
`endif
    end
  end

  // NOTE: each combinational block assigns a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (load) w_state_nxt = S_START;
      S_START:  if (w_bit_end) w_state_nxt = S_DATA;
      S_DATA:
        if (w_bit_end && (r_idx == LAST_IDX)) begin
`ifdef PISO_TX_PARITY_EN
          w_state_nxt = S_PARITY;
`else
          w_state_nxt = S_STOP;
`endif
        end
`ifdef PISO_TX_PARITY_EN
      S_PARITY: if (w_bit_end) w_state_nxt = S_STOP;
`endif
      S_STOP:   if (w_bit_end) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state and registered, so sout is
  // glitch-free and changes on the same edge the state does.
  always_comb begin
    w_cnt_nxt   = (r_state == S_IDLE || w_bit_end) ? '0 : r_cnt + CW'(1);
    w_idx_nxt   = r_idx;
    w_shreg_nxt = r_shreg;
`ifdef PISO_TX_PARITY_EN
    w_parity_nxt = r_parity;
`endif
    if (r_state == S_IDLE) begin
      w_idx_nxt = '0;
      if (load) begin
        w_shreg_nxt = d;
`ifdef PISO_TX_PARITY_EN
        w_parity_nxt = ^d;
`endif
      end
    end else if (r_state == S_DATA && w_bit_end) begin
      w_idx_nxt   = r_idx + IW'(1);
      w_shreg_nxt = r_shreg >> 1;
    end

    w_sout_nxt = 1'b1;
    case (w_state_nxt)
      S_START:  w_sout_nxt = 1'b0;
      S_DATA:   w_sout_nxt = w_shreg_nxt[0];
`ifdef PISO_TX_PARITY_EN
      S_PARITY: w_sout_nxt = w_parity_nxt;
`endif
      default:  w_sout_nxt = 1'b1;
    endcase

    w_ready_nxt = (w_state_nxt == S_IDLE);
    w_done_nxt  = (w_state_nxt == S_STOP) && (w_cnt_nxt == LAST_CNT);
  end

  assign sout  = r_sout;
  assign ready = r_ready;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule
